nios_display_system_key_pio: RTL
================================

// Module: nios_display_system_key_pio
// PURPOSE
//  Avalon-MM slave input PIO: the read-side counterpart of the LED output port.
//  Samples external keys/switches (in_port), synchronises and debounces them, and latches edges.
//  Raises a level interrupt to the Nios II for unmasked captured edges.
//  Sits on the Nios display system bus next to the LED PIO; 4-word register map, 32-bit data.
// PARAMETERS
//  WIDTH            4   number of input bits (1..32)
//  SYNC_STAGES      2   synchroniser flops per bit (>=2)
//  DEBOUNCE_CYCLES  0   stable cycles required before debounced bit changes; 0 = bypass
//  EDGE_TYPE        1   0 = rising, 1 = falling, 2 = any edge sets edge_capture
//  IDLE_LEVEL       {WIDTH{1'b1}}  reset value of synchroniser and debounced state (keys idle high)
// PORTS
//  clk         in   1      system clock
//  reset       in   1      asynchronous, active-high reset
//  address     in   2      word address
//  chipselect  in   1      slave select
//  write_n     in   1      active-low write strobe
//  writedata   in   32     write data
//  in_port     in   WIDTH  asynchronous external inputs
//  readdata    out  32     registered read data, read latency 1
//  irq         out  1      level interrupt, active high
// BEHAVIOUR
//  Reset (async, any time incl. mid-debounce): sync chain, debounced := IDLE_LEVEL;
//   debounce counters, irq_mask, edge_capture, readdata := 0; irq = 0. No edge captured on release.
//  Sync: in_port through SYNC_STAGES flops -> s[i].
//  Debounce (per bit, D = DEBOUNCE_CYCLES): cnt clears whenever s == deb. While s != deb:
//   cnt == D-1 -> deb toggles at this edge, cnt := 0; else cnt++. D = 0: deb = s (no counter).
//   Pulse on s shorter than D cycles never reaches deb. Counter width = clog2(D+1).
//  Edge detect: deb_d = deb delayed 1 clk; edge per EDGE_TYPE from (deb_d, deb).
//  Latency: in_port change sampled at edge 1 -> edge_capture bit set at edge SYNC_STAGES+D+1.
//  Register map (word address):
//   0 DATA   R: {0, deb}; writes ignored
//   1 -      R: 0; writes ignored
//   2 MASK   R/W: irq_mask[WIDTH-1:0]
//   3 EDGE   R: edge_capture; W: write-1-to-clear per bit
//  Write accepted when chipselect && !write_n; zero wait states.
//  readdata <= mux(address) every clk edge (read latency 1); bits [31:WIDTH] always 0.
//  Simultaneous new edge and W1C on same bit: set wins (bit stays 1).
//  irq = |(edge_capture & irq_mask), combinational from registers (no extra latency).
//  Mask write exposing an existing captured bit asserts irq the cycle after the write.
// STRUCTURE
//  Shared package nios_display_system_pio_pkg: register address constants
//   (PIO_ADDR_DATA=0, PIO_ADDR_MASK=2, PIO_ADDR_EDGE=3), EDGE_RISING/FALLING/ANY encodings.
//  Sub-module nios_display_system_debounce: one bit, sync chain + counter + deb flop,
//   instantiated WIDTH times via generate. Top holds edge detect, regs, read mux, irq.
// TESTING
//  1 Reset: assert reset mid-cycle with in_port=4'hF -> readdata=0, irq=0; after release,
//    read addr0 -> 32'h0000000F, addr3 -> 0 (no spurious edge).
//  2 D=0, EDGE_TYPE=1: in_port[2] 1->0 sampled at edge 1 -> edge_capture=4'h4 after edge 3;
//    mask=4'h4 written -> irq=1; write addr3 4'h4 -> irq=0 next cycle.
//  3 D=4: 3-cycle low glitch on in_port[0] -> DATA and EDGE unchanged; 6-cycle low ->
//    capture set after edge 7, DATA bit0 = 0.
//  4 Set-wins: W1C of bit1 on same edge bit1 capture sets -> EDGE reads 4'h2, irq stays 1.
//  5 EDGE_TYPE=2: toggle in_port[3] 0->1->0 with reads between -> each toggle sets bit3; masked
//    (mask=0) -> irq stays 0 while EDGE=4'h8.
//  6 Readback: write MASK 32'hFFFFFFF5 -> read 32'h00000005; write addr0/1 -> no state change.

Source files
------------

// File: rtl/nios_display_system_pio_pkg.sv
// Shared definitions for the Nios display system PIO blocks: register map and
// edge-detect encodings.
package nios_display_system_pio_pkg;

    localparam logic [1:0] PIO_ADDR_DATA = 2'd0;
    localparam logic [1:0] PIO_ADDR_RSVD = 2'd1;
    localparam logic [1:0] PIO_ADDR_MASK = 2'd2;
    localparam logic [1:0] PIO_ADDR_EDGE = 2'd3;

    typedef enum logic [1:0] {
        EDGE_RISING  = 2'd0,
        EDGE_FALLING = 2'd1,
        EDGE_ANY     = 2'd2
    } edge_type_e;

    function automatic logic edge_hit(input logic prev, input logic curr, input edge_type_e et);
        logic hit;
        case (et)
            EDGE_RISING:  hit = !prev && curr;
            EDGE_FALLING: hit = prev && !curr;
            EDGE_ANY:     hit = prev ^ curr;
            default:      hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/nios_display_system_key_pio_if.sv
// Avalon-MM slave bus of the key PIO, including its interrupt line.
interface nios_display_system_key_pio_if;

    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata, irq
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata, irq
    );

endinterface

// File: rtl/nios_display_system_debounce.sv
// One input bit: synchroniser chain followed by an optional stable-count debouncer.
module nios_display_system_debounce #(
    parameter int   SYNC_STAGES     = 2,
    parameter int   DEBOUNCE_CYCLES = 0,
    parameter logic IDLE_LEVEL      = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic in_bit,
    output logic deb_bit
);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   s_s;

    // synchroniser chain, oldest stage is the synchronised value
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_r <= {SYNC_STAGES{IDLE_LEVEL}};
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], in_bit};
        end
    end

    assign s_s = sync_r[SYNC_STAGES-1];

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_bypass
            assign deb_bit = s_s;
        end else begin : g_debounce
            localparam int             CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
            localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

            logic [CNT_W-1:0] cnt_r;
            logic             deb_r;

            // count consecutive cycles of disagreement; flip only after a full run
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    cnt_r <= '0;
                    deb_r <= IDLE_LEVEL;
                end else if (s_s == deb_r) begin
                    cnt_r <= '0;
                end else if (cnt_r == CNT_LAST) begin
                    cnt_r <= '0;
                    deb_r <= s_s;
                end else begin
                    cnt_r <= cnt_r + CNT_W'(1);
                end
            end

            assign deb_bit = deb_r;
        end
    endgenerate

endmodule

// File: rtl/nios_display_system_key_pio.sv
// Key/switch input PIO: debounced data, edge capture with W1C, interrupt mask,
// level irq to the Nios II.
module nios_display_system_key_pio
    import nios_display_system_pio_pkg::*;
#(
    parameter int               WIDTH           = 4,
    parameter int               SYNC_STAGES     = 2,
    parameter int               DEBOUNCE_CYCLES = 0,
    parameter edge_type_e       EDGE_TYPE       = EDGE_FALLING,
    parameter logic [WIDTH-1:0] IDLE_LEVEL      = {WIDTH{1'b1}}
) (
    input  logic                         clk,
    input  logic                         reset,
    nios_display_system_key_pio_if.slave bus,
    input  logic [WIDTH-1:0]             in_port
);

    logic [WIDTH-1:0] deb_s;
    logic [WIDTH-1:0] deb_d_r;
    logic [WIDTH-1:0] edge_s;
    logic [WIDTH-1:0] edge_capture_r;
    logic [WIDTH-1:0] irq_mask_r;
    logic [WIDTH-1:0] w1c_s;
    logic             wr_s;
    logic             mask_wr_s;
    logic [31:0]      rd_mux_s;
    logic [31:0]      readdata_r;

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            nios_display_system_debounce #(
                .SYNC_STAGES     (SYNC_STAGES),
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .IDLE_LEVEL      (IDLE_LEVEL[i])
            ) u_debounce (
                .clk     (clk),
                .reset   (reset),
                .in_bit  (in_port[i]),
                .deb_bit (deb_s[i])
            );
        end

        if (WIDTH < 32) begin : g_unused
            logic unused_wdata_s;
            assign unused_wdata_s = ^bus.writedata[31:WIDTH];
        end
    endgenerate

    // per-bit edge detect between the debounced value and its one-cycle delay
    always_comb begin
        edge_s = '0;
        for (int i = 0; i < WIDTH; i++) begin
            edge_s[i] = edge_hit(deb_d_r[i], deb_s[i], EDGE_TYPE);
        end
    end

    // bus write decode
    always_comb begin
        wr_s      = bus.chipselect && !bus.write_n;
        mask_wr_s = wr_s && (bus.address == PIO_ADDR_MASK);
        w1c_s     = (wr_s && (bus.address == PIO_ADDR_EDGE)) ? bus.writedata[WIDTH-1:0] : '0;
    end

    // read mux, registered below for one-cycle read latency
    always_comb begin
        rd_mux_s = 32'h0000_0000;
        case (bus.address)
            PIO_ADDR_DATA: rd_mux_s = 32'(deb_s);
            PIO_ADDR_RSVD: rd_mux_s = 32'h0000_0000;
            PIO_ADDR_MASK: rd_mux_s = 32'(irq_mask_r);
            PIO_ADDR_EDGE: rd_mux_s = 32'(edge_capture_r);
            default:       rd_mux_s = 32'h0000_0000;
        endcase
    end

    // register state; a new edge overrides a same-cycle clear of that bit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            deb_d_r        <= IDLE_LEVEL;
            edge_capture_r <= '0;
            irq_mask_r     <= '0;
            readdata_r     <= 32'h0000_0000;
        end else begin
            deb_d_r        <= deb_s;
            edge_capture_r <= (edge_capture_r & ~w1c_s) | edge_s;
            readdata_r     <= rd_mux_s;
            if (mask_wr_s) begin
                irq_mask_r <= bus.writedata[WIDTH-1:0];
            end else begin
                irq_mask_r <= irq_mask_r;
            end
        end
    end

    assign bus.readdata = readdata_r;
    assign bus.irq      = |(edge_capture_r & irq_mask_r);

endmodule
